prm_edge_mask_engine: RTL and testbench

Programmable obstacle/edge-collision checker for the PRM roadmap pipeline. It generalises the fixed 15-input sum-of-products edge checks into a loadable cube table. Each table entry is one product term (care mask, value, target edge). A streamed configuration-space vector is scanned against all terms, and a per-edge blocked mask is returned over a valid/ready handshake.

---
 rtl/prm_edge_mask_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_prm_edge_mask_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine
//   Programmable edge-collision checker. A loadable table of product terms
//   (enable, care mask, value, edge channel) is scanned TERM_PAR terms per
//   cycle against a latched query vector; every matching term sets its edge
//   bit in the result mask.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | table writable, waiting for a query
//   SCAN  | evaluating term group ptr..ptr+TERM_PAR-1, accumulating hits
//   DONE  | result presented on out_*, held until out_ready
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_we/cfg_ready    term write strobe / table writable (IDLE only)
//   cfg_addr            term index
//   cfg_en/care/val     term enable, care mask, required values
//   cfg_edge            edge channel of the term (>= N_EDGE is dropped)
//   in_valid/in_ready   query handshake, in_vec query vector
//   out_valid/out_ready result handshake
//   out_mask, out_any   per-edge blocked mask and its OR
//   busy                engine not in IDLE
//   hit_cnt             matching-term count (only with PRM_EDGE_MASK_HITCNT_EN)
//
// Optional feature macro: PRM_EDGE_MASK_HITCNT_EN
// N_TERM must be a multiple of TERM_PAR.
module prm_edge_mask_engine #(
  parameter int IN_W     = 15,
  parameter int N_EDGE   = 8,
  parameter int N_TERM   = 64,
  parameter int TERM_PAR = 4,
  parameter int AW       = $clog2(N_TERM),
  parameter int EW       = (N_EDGE > 1) ? $clog2(N_EDGE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  output logic              cfg_ready,
  input  logic [AW-1:0]     cfg_addr,
  input  logic              cfg_en,
  input  logic [IN_W-1:0]   cfg_care,
  input  logic [IN_W-1:0]   cfg_val,
  input  logic [EW-1:0]     cfg_edge,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_EDGE-1:0] out_mask,
  output logic              out_any,
  output logic              busy
`ifdef PRM_EDGE_MASK_HITCNT_EN
  ,
  output logic [AW:0]       hit_cnt
`endif
);

  localparam logic [AW-1:0] LAST_PTR = AW'(N_TERM - TERM_PAR);
  localparam logic [AW-1:0] PTR_STEP = AW'(TERM_PAR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [IN_W-1:0]     vec_q, vec_d;
  logic [N_EDGE-1:0]   acc_q, acc_d;
  logic [N_EDGE-1:0]   out_mask_q, out_mask_d;
  logic                out_any_q, out_any_d;
  logic [N_TERM-1:0]   en_q, en_d;

  // Term payload: only meaningful where the enable bit is set, so no reset.
  logic [IN_W-1:0]     care_q [N_TERM];
  logic [IN_W-1:0]     val_q  [N_TERM];
  logic [EW-1:0]       edge_q [N_TERM];

  logic                wr_ok;
  logic [AW-1:0]       term_idx [TERM_PAR];
  logic [TERM_PAR-1:0] hit_vec;
  logic [N_EDGE-1:0]   grp_mask;
  logic [N_EDGE-1:0]   acc_next;

  // ---------------------------------------------------------------------
  // Table write: only while IDLE, and only for addressable terms and edge
  // channels that exist. A write in the accept cycle lands before the
  // first scan cycle reads the table.
  // ---------------------------------------------------------------------
  assign wr_ok = cfg_we && (state_q == ST_IDLE)
                 && ((EW+1)'(cfg_edge) < (EW+1)'(N_EDGE))
                 && ((AW+1)'(cfg_addr) < (AW+1)'(N_TERM));

  always_comb begin
    en_d = en_q;
    if (wr_ok) begin
      en_d[cfg_addr] = cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      care_q[cfg_addr] <= cfg_care;
      val_q[cfg_addr]  <= cfg_val;
      edge_q[cfg_addr] <= cfg_edge;
    end
  end

  // ---------------------------------------------------------------------
  // Group evaluation for the current pointer
  // ---------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < TERM_PAR; i++) begin
      term_idx[i] = ptr_q + AW'(i);
    end
  end

  always_comb begin
    hit_vec  = '0;
    grp_mask = '0;
    for (int i = 0; i < TERM_PAR; i++) begin
      hit_vec[i] = en_q[term_idx[i]]
                   && (((vec_q ^ val_q[term_idx[i]]) & care_q[term_idx[i]]) == '0);
      if (hit_vec[i]) begin
        grp_mask = grp_mask | (N_EDGE'(1) << edge_q[term_idx[i]]);
      end
    end
  end

  assign acc_next = acc_q | grp_mask;

`ifdef PRM_EDGE_MASK_HITCNT_EN
  logic [AW:0]   hit_q, hit_d;
  logic [AW:0]   grp_cnt;
  logic [AW+1:0] hit_sum;

  always_comb begin
    grp_cnt = '0;
    for (int i = 0; i < TERM_PAR; i++) begin
      if (hit_vec[i]) begin
        grp_cnt = grp_cnt + (AW+1)'(1);
      end
    end
  end

  assign hit_sum = (AW+2)'(hit_q) + (AW+2)'(grp_cnt);

  always_comb begin
    hit_d = hit_q;
    if ((state_q == ST_IDLE) && in_valid) begin
      hit_d = '0;
    end else if (state_q == ST_SCAN) begin
      hit_d = (hit_sum > (AW+2)'(N_TERM)) ? (AW+1)'(N_TERM) : hit_sum[AW:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_cnt = hit_q;
`endif

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    vec_d      = vec_q;
    acc_d      = acc_q;
    out_mask_d = out_mask_q;
    out_any_d  = out_any_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          vec_d   = in_vec;
          acc_d   = '0;
          ptr_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        acc_d = acc_next;
        ptr_d = ptr_q + PTR_STEP;
        if (ptr_q == LAST_PTR) begin
          // Result registers load only on DONE entry, so they stay stable
          // across the DONE hold and the following IDLE/SCAN.
          out_mask_d = acc_next;
          out_any_d  = |acc_next;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      vec_q      <= '0;
      acc_q      <= '0;
      out_mask_q <= '0;
      out_any_q  <= 1'b0;
      en_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      vec_q      <= vec_d;
      acc_q      <= acc_d;
      out_mask_q <= out_mask_d;
      out_any_q  <= out_any_d;
      en_q       <= en_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_mask  = out_mask_q;
  assign out_any   = out_any_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Bench for prm_edge_mask_engine. Two instances share all inputs: the default
// 8-edge engine and a 6-edge engine. With a 3-bit edge index the default
// build cannot express an out-of-range edge, so the 6-edge instance is what
// sees edges 6 and 7 being dropped.
module tb_prm_edge_mask_engine;

  localparam int IN_W    = 15;
  localparam int N_TERM  = 64;
  localparam int LATENCY = 64 / 4 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic        cfg_en;
  logic [14:0] cfg_care;
  logic [14:0] cfg_val;
  logic [2:0]  cfg_edge;
  logic        in_valid;
  logic [14:0] in_vec;
  logic        out_ready;

  logic        cfg_ready, in_ready, out_valid, out_any, busy;
  logic [7:0]  out_mask;
  logic        cfg_ready6, in_ready6, out_valid6, out_any6, busy6;
  logic [5:0]  out_mask6;
`ifdef PRM_EDGE_MASK_HITCNT_EN
  logic [6:0]  hit_cnt, hit_cnt6;
`endif

  int checks = 0;
  int failures = 0;

  // Reference table per instance: [0] = 8 edges, [1] = 6 edges.
  logic        m_en   [2][N_TERM];
  logic [14:0] m_care [2][N_TERM];
  logic [14:0] m_val  [2][N_TERM];
  int          m_edge [2][N_TERM];

  always #5 clk = ~clk;

  prm_edge_mask_engine u_dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_en(cfg_en), .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_edge(cfg_edge),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_any(out_any), .busy(busy)
`ifdef PRM_EDGE_MASK_HITCNT_EN
    , .hit_cnt(hit_cnt)
`endif
  );

  prm_edge_mask_engine #(.N_EDGE(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready6), .cfg_addr(cfg_addr),
    .cfg_en(cfg_en), .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_edge(cfg_edge),
    .in_valid(in_valid), .in_ready(in_ready6), .in_vec(in_vec),
    .out_valid(out_valid6), .out_ready(out_ready),
    .out_mask(out_mask6), .out_any(out_any6), .busy(busy6)
`ifdef PRM_EDGE_MASK_HITCNT_EN
    , .hit_cnt(hit_cnt6)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < N_TERM; a++) m_en[t][a] = 1'b0;
  endfunction

  function automatic void model_write(input int addr, input logic en, input logic [14:0] care,
                                      input logic [14:0] val, input int edge_i);
    for (int t = 0; t < 2; t++) begin
      if (edge_i < ((t == 0) ? 8 : 6)) begin
        m_en[t][addr]   = en;
        m_care[t][addr] = care;
        m_val[t][addr]  = val;
        m_edge[t][addr] = edge_i;
      end
    end
  endfunction

  function automatic void model_eval(input int t, input logic [14:0] v,
                                     output logic [7:0] mask, output int cnt);
    mask = '0;
    cnt  = 0;
    for (int a = 0; a < N_TERM; a++) begin
      if (m_en[t][a] && (((v ^ m_val[t][a]) & m_care[t][a]) == 15'h0)) begin
        mask[m_edge[t][a]] = 1'b1;
        cnt++;
      end
    end
    if (cnt > N_TERM) cnt = N_TERM;
  endfunction

  // Called one time unit after a rising edge with the engine idle.
  task automatic cfg_write(input int addr, input logic en, input logic [14:0] care,
                           input logic [14:0] val, input int edge_i);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_en = en;
    cfg_care = care; cfg_val = val; cfg_edge = 3'(edge_i);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_write(addr, en, care, val, edge_i);
  endtask

  // Issues a query (any cfg_we already driven by the caller lands in the same
  // cycle), checks latency and result, holds DONE for `hold` cycles, and
  // optionally tries a table write while DONE that must be dropped.
  task automatic run_query(input logic [14:0] v, input int hold, input bit drop_wr);
    logic [7:0] e8, e6;
    int c8, c6, n;
    model_eval(0, v, e8, c8);
    model_eval(1, v, e6, c6);
    check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    in_vec   = 15'($urandom);
    check_eq("scan_busy", {31'd0, busy}, 32'd1);
    check_eq("scan_in_ready", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 32'(n + 1), 32'(LATENCY));
    check_eq("out_valid6", {31'd0, out_valid6}, 32'd1);
    check_eq("out_mask", {24'd0, out_mask}, {24'd0, e8});
    check_eq("out_any", {31'd0, out_any}, {31'd0, |e8});
    check_eq("out_mask6", {26'd0, out_mask6}, {26'd0, e6[5:0]});
    check_eq("out_any6", {31'd0, out_any6}, {31'd0, |e6});
`ifdef PRM_EDGE_MASK_HITCNT_EN
    check_eq("hit_cnt", {25'd0, hit_cnt}, 32'(c8));
    check_eq("hit_cnt6", {25'd0, hit_cnt6}, 32'(c6));
`endif
    for (int k = 0; k < hold; k++) begin
      if (drop_wr && k == 3) begin
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_en = 1'b1;
        cfg_care = 15'h0; cfg_val = 15'h0; cfg_edge = 3'd2;
        check_eq("done_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_mask", {24'd0, out_mask}, {24'd0, e8});
      check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("post_mask_kept", {24'd0, out_mask}, {24'd0, e8});
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_care = '0;
    cfg_val = '0; cfg_edge = '0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check_eq("rst_out_mask", {24'd0, out_mask}, 32'd0);
    check_eq("rst_out_any", {31'd0, out_any}, 32'd0);

    // Empty table
    run_query(15'h7FFF, 0, 1'b0);

    // Full-care cube on edge 3
    cfg_write(0, 1'b1, 15'h7FFF, 15'h1234, 3);
    run_query(15'h1234, 0, 1'b0);
    run_query(15'h1235, 0, 1'b0);

    // Single-bit term on edge 0, match-all term on edge 7 (dropped by 6-edge)
    cfg_write(5, 1'b1, 15'h0001, 15'h0001, 0);
    cfg_write(63, 1'b1, 15'h0000, 15'h0000, 7);
    run_query(15'h0001, 0, 1'b0);

    // Hold DONE 10 cycles with a write attempt to term 1 that must be dropped
    run_query(15'h0001, 10, 1'b1);
    run_query(15'h4000, 0, 1'b0);

    // Edge 6: kept by the 8-edge engine, dropped by the 6-edge engine
    cfg_write(10, 1'b1, 15'h7FFF, 15'h0ABC, 6);
    run_query(15'h0ABC, 0, 1'b0);

    // Write and query in the same cycle: scan sees the new term
    cfg_we = 1'b1; cfg_addr = 6'd20; cfg_en = 1'b1;
    cfg_care = 15'h00F0; cfg_val = 15'h0050; cfg_edge = 3'd1;
    model_write(20, 1'b1, 15'h00F0, 15'h0050, 1);
    run_query(15'h0055, 0, 1'b0);

    // Randomised table updates and queries
    for (int r = 0; r < 14; r++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        cfg_write(int'($urandom_range(0, 62)), 1'($urandom_range(0, 3) != 0),
                  15'($urandom & $urandom & $urandom), 15'($urandom),
                  int'($urandom_range(0, 7)));
      end
      run_query(15'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset in the middle of a scan
    in_valid = 1'b1;
    in_vec   = 15'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("midrst_out_mask", {24'd0, out_mask}, 32'd0);
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    // Term 63 matched everything before the reset; a cleared table must not.
    run_query(15'h0001, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
